// File: rtl/qysys_test_led_sequencer.sv
// LED pattern sequencer: an Avalon-MM slave holding a small pattern table that
// replays the table into the LED PIO through a registered write-only master port.
module qysys_test_led_sequencer #(
  parameter int PRESCALE_W = 24,
  parameter int DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [1:0]  led_address,
  output logic        led_chipselect,
  output logic        led_write_n,
  output logic [31:0] led_writedata,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WAIT = 2'd2} state_t;

  state_t                state, state_nxt;
  logic                  loop_q, irq_en_q, done_q;
  logic [PRESCALE_W-1:0] period_q, counter_q;
  logic [3:0]            length_q, len_eff;
  logic [7:0]            manual_q;
  logic [7:0]            pattern_q [DEPTH];
  logic [2:0]            idx_q;
  logic                  wr, wr_ctrl, wr_status, wr_manual, busy, last;
  logic                  start, abort, step, wrap, finish;
  logic                  unused_bits;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == 4'd0);
  assign wr_status = wr && (address == 4'd1);
  assign wr_manual = wr && (address == 4'd4);
  assign busy      = (state != IDLE);
  assign unused_bits = ^{writedata[31:PRESCALE_W]};

  // Zero means one entry; anything beyond the table is clamped to the table size.
  assign len_eff = (length_q == 4'd0) ? 4'd1 :
                   (length_q > 4'(DEPTH)) ? 4'(DEPTH) : length_q;
  assign last    = ({1'b0, idx_q} == (len_eff - 4'd1));

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    step      = 1'b0;
    wrap      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (wr_ctrl && writedata[0]) begin
        state_nxt = WRITE;
        start     = 1'b1;
      end
      WRITE: state_nxt = WAIT;
      WAIT: if (counter_q == '0) begin
        if (!last) begin
          state_nxt = WRITE;
          step      = 1'b1;
        end else if (loop_q) begin
          state_nxt = WRITE;
          wrap      = 1'b1;
        end else begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Clearing RUN while busy overrides everything, including a pending strobe.
    if (busy && wr_ctrl && !writedata[0]) begin
      state_nxt = IDLE;
      abort     = 1'b1;
      step      = 1'b0;
      wrap      = 1'b0;
      finish    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      loop_q         <= 1'b0;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      period_q       <= '0;
      counter_q      <= '0;
      length_q       <= '0;
      manual_q       <= '0;
      idx_q          <= '0;
      led_chipselect <= 1'b0;
      led_write_n    <= 1'b1;
      led_writedata  <= '0;
      for (int i = 0; i < DEPTH; i++) pattern_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (wr_ctrl) begin
        loop_q   <= writedata[1];
        irq_en_q <= writedata[2];
      end
      if (wr && address == 4'd2) period_q <= writedata[PRESCALE_W-1:0];
      if (wr && address == 4'd3) length_q <= writedata[3:0];
      if (wr_manual)             manual_q <= writedata[7:0];
      if (wr && address[3])      pattern_q[address[2:0]] <= writedata[7:0];

      if (wr_status) done_q <= 1'b0;
      if (finish)    done_q <= 1'b1;
      if (start)     done_q <= 1'b0;

      if (start || wrap) idx_q <= '0;
      else if (step)     idx_q <= idx_q + 3'd1;

      if (state == WRITE && !abort)               counter_q <= period_q;
      else if (state == WAIT && counter_q != '0)  counter_q <= counter_q - 1'b1;

      led_chipselect <= 1'b0;
      led_write_n    <= 1'b1;
      if (state == WRITE && !abort) begin
        led_chipselect <= 1'b1;
        led_write_n    <= 1'b0;
        led_writedata  <= {24'b0, pattern_q[idx_q]};
      end else if (state == IDLE && wr_manual) begin
        led_chipselect <= 1'b1;
        led_write_n    <= 1'b0;
        led_writedata  <= {24'b0, writedata[7:0]};
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      4'd0:    readdata = {29'b0, irq_en_q, loop_q, busy};
      4'd1:    readdata = {25'b0, idx_q, 2'b00, done_q, busy};
      4'd2:    readdata = {{(32-PRESCALE_W){1'b0}}, period_q};
      4'd3:    readdata = {28'b0, length_q};
      4'd4:    readdata = {24'b0, manual_q};
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
               readdata = {24'b0, pattern_q[address[2:0]]};
      default: readdata = '0;
    endcase
  end

  assign irq         = done_q & irq_en_q;
  assign led_address = 2'b00;
  assign fsm_state   = state;

endmodule

// File: tb/tb_qysys_test_led_sequencer.sv
// Bench for the LED sequencer: an edge-indexed schedule of expected PIO strobes,
// derived from the programmed table/period/length, is compared every cycle.
module tb_qysys_test_led_sequencer;

  // Handshake: a slave write is one cycle with chipselect=1, write_n=0; a PIO
  // strobe is one cycle with led_chipselect=1, led_write_n=0 carrying the data.

  localparam int INF = 1 << 30;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [1:0]  led_address;
  logic        led_chipselect;
  logic        led_write_n;
  logic [31:0] led_writedata;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  qysys_test_led_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .led_address(led_address), .led_chipselect(led_chipselect),
    .led_write_n(led_write_n), .led_writedata(led_writedata), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0]  m_pat [8];
  logic [23:0] m_period;
  logic [3:0]  m_len;
  logic [7:0]  m_manual;
  logic        m_loop, m_irq_en;
  int          run_start = INF;
  int          busy_end  = 0;
  int          done_set  = INF;
  logic [7:0]  exp_strobe [int];   // edge number -> expected LED byte
  logic [7:0]  exp_q [$];
  int          log_edge [$];
  logic [7:0]  log_data [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%08h expected 0x%08h", name, edge_n, act, exp);
    end
  endtask

  function automatic bit m_busy(input int n);
    return (n >= run_start) && (n < busy_end);
  endfunction

  function automatic bit m_done(input int n);
    return n >= done_set;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a, input int n);
    case (a)
      4'd0:    return {29'b0, m_irq_en, m_loop, m_busy(n)};
      4'd1:    return {30'b0, m_done(n), m_busy(n)};
      4'd2:    return {8'b0, m_period};
      4'd3:    return {28'b0, m_len};
      4'd4:    return {24'b0, m_manual};
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
               return {24'b0, m_pat[a[2:0]]};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
    m_period = '0; m_len = '0; m_manual = '0; m_loop = 0; m_irq_en = 0;
    run_start = INF; busy_end = 0; done_set = INF;
    exp_strobe.delete();
  endtask

  // Effect of a slave write sampled at edge e.
  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input int e);
    bit bz;
    int keys [$];
    int len, per, cnt;
    bz = m_busy(e - 1);
    case (a)
      4'd0: begin
        if (d[0] && !bz) begin
          len = (m_len == 0) ? 1 : ((m_len > 8) ? 8 : int'(m_len));
          per = int'(m_period);
          cnt = d[1] ? 200 : len;
          for (int k = 0; k < cnt; k++) exp_strobe[e + 1 + k * (per + 2)] = m_pat[k % len];
          run_start = e;
          done_set  = d[1] ? INF : e + 1 + (len - 1) * (per + 2) + per + 1;
          busy_end  = done_set;
        end else if (!d[0] && bz) begin
          foreach (exp_strobe[k]) if (k >= e) keys.push_back(k);
          foreach (keys[i]) exp_strobe.delete(keys[i]);
          busy_end = e;
          done_set = INF;
        end
        m_loop   = d[1];
        m_irq_en = d[2];
      end
      4'd1: if (done_set < e) done_set = INF;
      4'd2: m_period = d[23:0];
      4'd3: m_len = d[3:0];
      4'd4: begin
        m_manual = d[7:0];
        if (!bz) exp_strobe[e] = d[7:0];
      end
      default: if (a[3]) m_pat[a[2:0]] = d[7:0];
    endcase
  endtask

  // Per-cycle compare of the PIO master port and irq against the model.
  always @(negedge clk) begin : compare
    int n;
    if (reset_n) begin
      n = edge_n;
      if (led_chipselect) begin
        log_edge.push_back(n);
        log_data.push_back(led_writedata[7:0]);
      end
      if (exp_strobe.exists(n)) begin
        check("strobe_ctl", {30'b0, led_chipselect, led_write_n}, 32'h2);
        check("strobe_data", led_writedata, {24'b0, exp_strobe[n]});
        exp_strobe.delete(n);
      end else begin
        check("bus_quiet", {30'b0, led_chipselect, led_write_n}, 32'h1);
      end
      check("irq", {31'b0, irq}, {31'b0, m_done(n) & m_irq_en});
      check("led_address", {30'b0, led_address}, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int e);
    e = edge_n + 1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    model_write(a, d, e);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int e;
    bus_write(a, d, e);
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [31:0] mask, input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(name, readdata & mask, m_read(a, edge_n) & mask);
    chipselect = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_lit(input logic [3:0] a, input logic [31:0] mask, input logic [31:0] exp,
                          input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(name, readdata & mask, exp);
    chipselect = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    #1;
    log_edge.delete();
    log_data.delete();
  endtask

  task automatic check_log(input string name);
    #1;
    check({name, "_count"}, log_data.size(), exp_q.size());
    if (log_data.size() == exp_q.size())
      foreach (exp_q[i]) check({name, "_data"}, {24'b0, log_data[i]}, {24'b0, exp_q[i]});
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int e0;
    int lp, ie;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    model_reset();
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(1);

    // Reset state.
    check("rst_led_cs", {31'b0, led_chipselect}, 32'h0);
    check("rst_led_wn", {31'b0, led_write_n}, 32'h1);
    check("rst_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 16; a++) read_lit(4'(a), 32'hFFFF_FFFF, 32'h0, "rst_read");

    // One-shot run of three entries, period 3.
    wr(4'd8, 32'h01); wr(4'd9, 32'h02); wr(4'd10, 32'h04);
    wr(4'd3, 32'd3); wr(4'd2, 32'd3);
    clear_log();
    bus_write(4'd0, 32'h5, e0);
    wait_cycles(25);
    exp_q = '{8'h01, 8'h02, 8'h04};
    check_log("oneshot");
    if (log_edge.size() == 3) begin
      check("oneshot_first_edge", log_edge[0], e0 + 1);
      check("oneshot_gap01", log_edge[1] - log_edge[0], 5);
      check("oneshot_gap12", log_edge[2] - log_edge[1], 5);
    end
    read_lit(4'd1, 32'h3, 32'h2, "oneshot_status");
    check("oneshot_irq", {31'b0, irq}, 32'h1);
    read_lit(4'd0, 32'h7, 32'h4, "oneshot_control");
    wr(4'd1, 32'h0);
    #1 check("irq_cleared", {31'b0, irq}, 32'h0);

    // Looping run, abort after seven strobes.
    wait_cycles(1);
    clear_log();
    wr(4'd0, 32'h3);
    for (int i = 0; i < 100 && log_data.size() < 7; i++) begin
      @(negedge clk);
      #1;
    end
    wr(4'd0, 32'h0);
    wait_cycles(20);
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04, 8'h01};
    check_log("loop_abort");
    read_lit(4'd1, 32'h3, 32'h0, "abort_status");

    // LENGTH=0 / PERIOD=0, then LENGTH clamped to the table.
    for (int i = 3; i < 8; i++) wr(4'(8 + i), 32'(1 << i));
    wr(4'd3, 32'd0); wr(4'd2, 32'd0);
    clear_log();
    bus_write(4'd0, 32'h1, e0);
    wait_cycles(1);
    read_lit(4'd1, 32'h3, 32'h1, "len0_busy");
    read_lit(4'd1, 32'h3, 32'h2, "len0_done");
    exp_q = '{8'h01};
    check_log("len0");
    if (log_edge.size() == 1) check("len0_edge", log_edge[0], e0 + 1);
    wr(4'd3, 32'd12);
    clear_log();
    wr(4'd0, 32'h1);
    wait_cycles(30);
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    check_log("len12");

    // MANUAL in idle and during a run.
    wr(4'd1, 32'h0);
    clear_log();
    bus_write(4'd4, 32'hA5, e0);
    exp_q = '{8'hA5};
    check_log("manual_idle");
    if (log_edge.size() == 1) check("manual_edge", log_edge[0], e0);
    check("manual_wdata", led_writedata, 32'h0000_00A5);
    wr(4'd3, 32'd3); wr(4'd2, 32'd3);
    clear_log();
    wr(4'd0, 32'h1);
    wait_cycles(3);
    wr(4'd4, 32'h5A);
    wait_cycles(20);
    exp_q = '{8'h01, 8'h02, 8'h04};
    check_log("manual_busy");
    read_lit(4'd4, 32'hFF, 32'h5A, "manual_read");

    // Reset in the middle of a looping run.
    wr(4'd0, 32'h7);
    wait_cycles(8);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_led_cs", {31'b0, led_chipselect}, 32'h0);
    check("arst_led_wn", {31'b0, led_write_n}, 32'h1);
    check("arst_led_wdata", led_writedata, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    wait_cycles(2);
    reset_n = 1'b1;
    clear_log();
    wait_cycles(20);
    exp_q = {};
    check_log("after_reset");
    read_lit(4'd8, 32'hFF, 32'h0, "after_reset_pattern");

    // Randomized runs against the model.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'($urandom_range(0, 255)));
      wr(4'd3, 32'($urandom_range(0, 15)));
      wr(4'd2, 32'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) wr(4'd4, 32'($urandom_range(0, 255)));
      lp = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ie = $urandom_range(0, 1);
      wr(4'd0, {29'b0, 1'(ie), 1'(lp), 1'b1});
      repeat ($urandom_range(0, 3)) begin
        wait_cycles($urandom_range(0, 5));
        wr(4'd4, 32'($urandom_range(0, 255)));
        read_chk(4'd0, 32'h7, "rand_control_run");
      end
      if (lp == 1) begin
        wait_cycles($urandom_range(5, 40));
        wr(4'd0, {29'b0, 1'(ie), 2'b00});
      end else begin
        for (int i = 0; i < 400 && m_busy(edge_n); i++) @(negedge clk);
      end
      wait_cycles(2);
      read_chk(4'd0, 32'h7, "rand_control");
      read_chk(4'd1, 32'h3, "rand_status");
      read_chk(4'd2, 32'hFF_FFFF, "rand_period");
      read_chk(4'd3, 32'hF, "rand_length");
      read_chk(4'd4, 32'hFF, "rand_manual");
      if ($urandom_range(0, 1) == 1) wr(4'd1, 32'h0);
    end

    wait_cycles(5);
    check("leftover_strobes", exp_strobe.num(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qysys_test_led_sequencer.md
Name: qysys_test_led_sequencer

Overview:
- Avalon-MM slave controller that sequences the 8-bit LED PIO output register.
- The CPU loads a pattern table of up to 8 entries, a step period and a step count, then sets RUN.
- The block drives the PIO s1 slave through its own registered write-only master port, writing one pattern entry per step, either once or looping.
- When idle, the CPU can write the LED value directly through the MANUAL register.

Parameters:
PRESCALE_W, 24, width of the PERIOD register and step counter
DEPTH, 8, number of pattern entries (fixed address map assumes ≤8)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  4  slave word address
chipselect  in  1  slave select
write_n  in  1  slave write strobe, active low
writedata  in  32  slave write data
readdata  out  32  slave read data, combinational mux on address
irq  out  1  done & CONTROL.IRQ_EN
led_address  out  2  master address to PIO, always 0
led_chipselect  out  1  master select to PIO
led_write_n  out  1  master write strobe to PIO, active low
led_writedata  out  32  master write data {24'b0, value}

Behaviour:
- Reset (async, reset_n=0):
  - All registers, the pattern table, idx, counter and done clear to 0; FSM goes to IDLE.
  - Outputs: led_chipselect=0, led_write_n=1, led_address=0, led_writedata=0, irq=0.
- Slave write: chipselect & ~write_n. No wait states; one access per cycle.
- Register map (readdata upper bits are zero):
  - 0 CONTROL: [0] RUN, [1] LOOP, [2] IRQ_EN. Reads return the current values; RUN reads 1 while busy.
  - 1 STATUS: RO. [0] busy, [1] done, [6:4] idx. Any write clears done.
  - 2 PERIOD: [PRESCALE_W-1:0].
  - 3 LENGTH: [3:0]. Effective length = 1 if 0; DEPTH if >DEPTH.
  - 4 MANUAL: [7:0]. Reads return the last value written.
  - 8..15 PATTERN[0..7]: [7:0].
  - All other addresses read 0; writes to them are ignored.
- FSM states: IDLE, WRITE, WAIT.
  - IDLE → WRITE when CONTROL is written with RUN=1. Same edge: idx←0, done←0.
  - WRITE, one cycle:
    - Registered outputs assert led_chipselect=1, led_write_n=0, led_writedata={24'b0, PATTERN[idx]}.
    - counter←PERIOD.
    - Next state WAIT.
  - WAIT: if counter≠0, counter←counter−1. If counter==0:
    - idx < len−1: idx←idx+1, go to WRITE.
    - idx == len−1 and LOOP=1: idx←0, go to WRITE.
    - idx == len−1 and LOOP=0: RUN←0, done←1, go to IDLE.
  - Spacing between consecutive PIO write strobes is exactly PERIOD+2 cycles.
  - The first strobe appears on the cycle after the CONTROL write is sampled; the strobe is registered, so it is visible 1 cycle after entering WRITE.
- Abort: writing CONTROL with RUN=0 while busy puts the FSM in IDLE on the next edge.
  - No further PIO writes; done stays 0; the LEDs hold their last value.
  - A strobe already registered still completes.
- Writing RUN=1 while busy does not restart; LOOP and IRQ_EN update immediately.
- LOOP cleared mid-run takes effect at the next end-of-sequence check.
- PERIOD, LENGTH and PATTERN writes during a run take effect at their next use: PERIOD at the next WRITE, LENGTH at the next end check, PATTERN[i] at the next WRITE of i.
- MANUAL writes:
  - In IDLE: MANUAL←writedata[7:0], and one PIO write strobe of that value is issued the next cycle.
  - While busy: the register updates but no PIO write is issued.
- led_address is constant 0; led_chipselect and led_write_n are strobed for exactly 1 cycle per write.
- irq is level: it stays high while done & IRQ_EN, and deasserts when STATUS is written or a new run starts.
- Reset asserted mid-run aborts immediately to reset values; no done, no irq.

Test Plan:
- Reset, then read addresses 0–4 and 8–15 → all 0; led_write_n=1, led_chipselect=0, irq=0.
- PATTERN[0..2]=0x01,0x02,0x04; LENGTH=3; PERIOD=3; CONTROL=0x5 → exactly 3 PIO writes with data 0x01, 0x02, 0x04, strobes 5 cycles apart; then STATUS=0x2, irq=1, CONTROL reads 0x4; writing STATUS drops irq.
- Same setup with LOOP=1 (CONTROL=0x3), observe 7 strobes → data 01,02,04,01,02,04,01; then write CONTROL=0 → no further strobes, STATUS.busy=0, done=0.
- LENGTH=0 with PERIOD=0 → single write of PATTERN[0], done after 2 cycles; LENGTH=12 → 8 writes covering PATTERN[0..7].
- In IDLE write MANUAL=0xA5 → one strobe next cycle, led_writedata=0x000000A5; during a run, write MANUAL=0x5A → no extra strobe, MANUAL reads 0x5A.
- Assert reset_n=0 during WAIT of a looping run → outputs return to reset values asynchronously; after release no strobes until RUN is rewritten.
